// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver config sequencing, FWFT byte FIFO and error statistics
// Optional feature macro: UART_RX_CTRL_ERR_CNT_EN (parity/stop error counters)
module uart_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [5:0]            cfg_prescale,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic                  rx_busy,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  input  logic                  rx_par_err,
  input  logic                  rx_stop_err,
  output logic                  rx_enable,
  output logic [5:0]            rx_prescale,
  output logic                  rx_par_en,
  output logic                  rx_par_typ,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  overrun,
  input  logic                  clr_stat,
  output logic [7:0]            par_err_cnt,
  output logic [7:0]            frame_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_APPLY, ST_SETTLE} state_t;

  state_t     state, state_n;
  logic [3:0] settle_cnt;
  logic [5:0] sh_prescale;
  logic       sh_par_en, sh_par_typ;
  logic       presc_legal, cfg_accept;

  assign presc_legal = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
  assign cfg_accept  = (state == ST_RUN) && cfg_valid && presc_legal;

  // Next-state and Moore outputs of the config sequencer
  always_comb begin
    state_n   = state;
    rx_enable = 1'b0;
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    case (state)
      ST_RUN: begin
        rx_enable = 1'b1;
        cfg_ready = 1'b1;
        if (cfg_accept) state_n = ST_HOLD;
      end
      ST_HOLD:   if (!rx_busy) state_n = ST_APPLY;
      ST_APPLY: begin
        cfg_done = 1'b1;
        state_n  = ST_SETTLE;
      end
      ST_SETTLE: if (settle_cnt == 4'd0) state_n = ST_RUN;
      default:   state_n = ST_SETTLE;
    endcase
  end

  // State register, settle counter, shadow and applied config, reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SETTLE;
      settle_cnt  <= SETTLE_INIT;
      sh_prescale <= 6'd8;
      sh_par_en   <= 1'b0;
      sh_par_typ  <= 1'b0;
      rx_prescale <= 6'd8;
      rx_par_en   <= 1'b0;
      rx_par_typ  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state   <= state_n;
      cfg_err <= (state == ST_RUN) && cfg_valid && !presc_legal;
      if (cfg_accept) begin
        sh_prescale <= cfg_prescale;
        sh_par_en   <= cfg_par_en;
        sh_par_typ  <= cfg_par_typ;
      end
      if (state == ST_APPLY) begin
        rx_prescale <= sh_prescale;
        rx_par_en   <= sh_par_en;
        rx_par_typ  <= sh_par_typ;
        settle_cnt  <= SETTLE_INIT;
      end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full, do_push, do_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = rd_en && !fifo_empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then
  assign do_push    = rx_data_valid && (!fifo_full || rd_en);
  assign rd_valid   = !fifo_empty;
  assign rd_data    = mem[rd_ptr[AW-1:0]];

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  // FIFO pointers and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (clr_stat)
        overrun <= 1'b0;
      else if (rx_data_valid && fifo_full && !rd_en)
        overrun <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_ERR_CNT_EN
  // Saturating error counters; clear has priority over a same-cycle strobe
  always_ff @(posedge clk) begin
    if (rst || clr_stat) begin
      par_err_cnt   <= 8'd0;
      frame_err_cnt <= 8'd0;
    end else begin
      if (rx_par_err && par_err_cnt != 8'hFF)     par_err_cnt   <= par_err_cnt + 8'd1;
      if (rx_stop_err && frame_err_cnt != 8'hFF)  frame_err_cnt <= frame_err_cnt + 8'd1;
    end
  end
`else
  assign par_err_cnt   = 8'd0;
  assign frame_err_cnt = 8'd0;
  logic unused_err_strobes;
  assign unused_err_strobes = &{1'b0, rx_par_err, rx_stop_err};
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en, cfg_par_typ;
  logic       cfg_ready, cfg_done, cfg_err;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_par_err, rx_stop_err;
  logic       rx_enable;
  logic [5:0] rx_prescale;
  logic       rx_par_en, rx_par_typ;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid, overrun, clr_stat;
  logic [7:0] par_err_cnt, frame_err_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef UART_RX_CTRL_ERR_CNT_EN
  localparam logic [7:0] EXP_PAR_SAT = 8'd255;
  localparam logic [7:0] EXP_STOP3   = 8'd3;
`else
  localparam logic [7:0] EXP_PAR_SAT = 8'd0;
  localparam logic [7:0] EXP_STOP3   = 8'd0;
`endif

  uart_rx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
    .cfg_par_typ(cfg_par_typ), .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .rx_busy(rx_busy), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_par_err(rx_par_err), .rx_stop_err(rx_stop_err),
    .rx_enable(rx_enable), .rx_prescale(rx_prescale), .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .overrun(overrun),
    .clr_stat(clr_stat), .par_err_cnt(par_err_cnt), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    rx_data = d;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), 32'(d));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  logic [7:0] fill_a [4];
  logic [7:0] fill_b [4];

  initial begin
    fill_a[0] = 8'hA1; fill_a[1] = 8'hB2; fill_a[2] = 8'hC3; fill_a[3] = 8'hD4;
    fill_b[0] = 8'h11; fill_b[1] = 8'h22; fill_b[2] = 8'h33; fill_b[3] = 8'h44;
    rst = 1'b1; cfg_valid = 1'b0; cfg_prescale = 6'd8; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    rx_busy = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stop_err = 1'b0;
    rd_en = 1'b0; clr_stat = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state: gated for two cycles, default config, empty FIFO
    check("rst_rx_enable", 32'(rx_enable), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_prescale", 32'(rx_prescale), 32'd8);
    check("rst_par", 32'({rx_par_en, rx_par_typ}), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_cnts", 32'({par_err_cnt, frame_err_cnt}), 32'd0);
    tick();
    check("settle1_rx_enable", 32'(rx_enable), 32'd0);
    tick();
    check("run_rx_enable", 32'(rx_enable), 32'd1);
    check("run_cfg_ready", 32'(cfg_ready), 32'd1);

    // Illegal prescale rejected, config unchanged
    cfg_valid = 1'b1; cfg_prescale = 6'd12; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("bad_cfg_err", 32'(cfg_err), 32'd1);
    check("bad_cfg_ready", 32'(cfg_ready), 32'd1);
    check("bad_rx_enable", 32'(rx_enable), 32'd1);
    tick();
    check("bad_cfg_err_pulse", 32'(cfg_err), 32'd0);
    check("bad_cfg_keep", 32'({rx_prescale, rx_par_en, rx_par_typ}), 32'({6'd8, 2'b00}));

    // Legal config while a frame is in flight; held cfg_valid must not re-capture
    rx_busy = 1'b1;
    cfg_valid = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
    tick();
    cfg_prescale = 6'd32; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("hold_rx_enable", 32'(rx_enable), 32'd0);
      check("hold_cfg_done", 32'(cfg_done), 32'd0);
      tick();
    end
    check("hold_cfg_ready", 32'(cfg_ready), 32'd0);
    rx_busy = 1'b0; cfg_valid = 1'b0;
    tick();
    check("apply_cfg_done", 32'(cfg_done), 32'd1);
    check("apply_old_presc", 32'(rx_prescale), 32'd8);
    tick();
    check("settle_cfg_done", 32'(cfg_done), 32'd0);
    check("new_cfg", 32'({rx_prescale, rx_par_en, rx_par_typ}), 32'({6'd16, 2'b11}));
    check("settle_a_rx_enable", 32'(rx_enable), 32'd0);
    tick();
    check("settle_b_rx_enable", 32'(rx_enable), 32'd0);
    tick();
    check("back_rx_enable", 32'(rx_enable), 32'd1);

    // FIFO fill, overrun on fifth byte, drain in order
    for (int i = 0; i < 4; i++) begin
      push(fill_a[i]);
      check("fill_head", 32'(rd_data), 32'hA1);
    end
    push(8'hE5);
    check("ovr_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) pop_expect("drain_a", fill_a[i]);
    check("drain_empty", 32'(rd_valid), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_empty_ignored", 32'(rd_valid), 32'd0);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 4; i++) push(fill_b[i]);
    rd_en = 1'b1; rx_data = 8'h5A; rx_data_valid = 1'b1;
    tick();
    rd_en = 1'b0; rx_data_valid = 1'b0;
    check("simul_ovr", 32'(overrun), 32'd0);
    pop_expect("simul_b1", 8'h22);
    pop_expect("simul_b2", 8'h33);
    pop_expect("simul_b3", 8'h44);
    pop_expect("simul_new", 8'h5A);
    check("simul_empty", 32'(rd_valid), 32'd0);

    // Error counters: saturation and clear priority
    rx_par_err = 1'b1;
    repeat (300) tick();
    rx_par_err = 1'b0;
    check("par_sat", 32'(par_err_cnt), 32'(EXP_PAR_SAT));
    rx_stop_err = 1'b1;
    repeat (3) tick();
    rx_stop_err = 1'b0;
    check("stop_cnt", 32'(frame_err_cnt), 32'(EXP_STOP3));
    clr_stat = 1'b1; rx_par_err = 1'b1;
    tick();
    clr_stat = 1'b0; rx_par_err = 1'b0;
    check("clr_par", 32'(par_err_cnt), 32'd0);
    check("clr_stop", 32'(frame_err_cnt), 32'd0);

    // Reset mid-config discards shadow config and FIFO contents
    rx_data = 8'h77; rx_data_valid = 1'b1;
    cfg_valid = 1'b1; cfg_prescale = 6'd32;
    tick();
    rx_data_valid = 1'b0; cfg_valid = 1'b0;
    check("pre_rst_hold", 32'(cfg_ready), 32'd0);
    check("pre_rst_fifo", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cfg", 32'({rx_prescale, rx_par_en, rx_par_typ}), 32'({6'd8, 2'b00}));
    check("mid_rst_fifo", 32'(rd_valid), 32'd0);
    check("mid_rst_rx_enable", 32'(rx_enable), 32'd0);
    tick(); tick();
    check("post_rst_rx_enable", 32'(rx_enable), 32'd1);
    check("post_rst_presc", 32'(rx_prescale), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
